// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single GPR write port and single RR write port
//   between two writeback sources: A (main ALU/load pipeline) and B (multi-cycle
//   mul/div unit). A has fixed priority; an optional starvation guard forces a
//   B grant after B has been refused STARVE_LIMIT consecutive cycles. The
//   winning write is registered and driven straight into the register file.
//
//   Optional feature macro: WB_STARVE_GUARD_EN
//     defined   -> starvation counter, force_b and b_starving are active
//     undefined -> strict A priority, b_starving tied 0
//
//   Ports
//     clk, reset_n                       clock (rising edge), async active-low reset
//     a_valid/a_ready/a_rd/a_data/a_to_rr  source A write handshake and payload
//     b_valid/b_ready/b_rd/b_data/b_to_rr  source B write handshake and payload
//     rf_we/rf_rd/rf_wd                  registered GPR write port (pulse per write)
//     rf_rr_we/rf_rr_in                  registered RR write port (pulse per write)
//     b_starving                         force_b currently active

module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_rd,
  input  logic [15:0] a_data,
  input  logic        a_to_rr,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [2:0]  b_rd,
  input  logic [15:0] b_data,
  input  logic        b_to_rr,
  output logic        rf_we,
  output logic [2:0]  rf_rd,
  output logic [15:0] rf_wd,
  output logic        rf_rr_we,
  output logic [15:0] rf_rr_in,
  output logic        b_starving
);

  logic        w_force_b;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_sel_to_rr;
  logic [2:0]  w_sel_rd;
  logic [15:0] w_sel_data;

`ifdef WB_STARVE_GUARD_EN
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_b = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts consecutive refused cycles of a pending B write. Any cycle where B
  // is not both pending and refused (transfer or idle) restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (b_valid && !b_ready) begin
      if (!w_force_b) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end
`else
  assign w_force_b = 1'b0;

  // Parameters only matter with the guard built in.
  logic [CNT_W-1:0] w_unused_limit;
  assign w_unused_limit = CNT_W'(STARVE_LIMIT);
`endif

  assign b_starving = w_force_b;

  assign a_ready = !(w_force_b && b_valid);
  assign b_ready = !a_valid || w_force_b;

  assign w_grant_a = a_valid && a_ready;
  assign w_grant_b = b_valid && b_ready && !w_grant_a;

  always_comb begin
    w_sel_to_rr = b_to_rr;
    w_sel_rd    = b_rd;
    w_sel_data  = b_data;
    if (w_grant_a) begin
      w_sel_to_rr = a_to_rr;
      w_sel_rd    = a_rd;
      w_sel_data  = a_data;
    end
  end

  // Enables pulse for one cycle per transfer; address/data hold their last
  // written values. GPR writes to index 0 are accepted but dropped here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wd    <= '0;
      rf_rr_we <= 1'b0;
      rf_rr_in <= '0;
    end else begin
      rf_we    <= 1'b0;
      rf_rr_we <= 1'b0;
      if (w_grant_a || w_grant_b) begin
        if (w_sel_to_rr) begin
          rf_rr_we <= 1'b1;
          rf_rr_in <= w_sel_data;
        end else if (w_sel_rd != 3'd0) begin
          rf_we <= 1'b1;
          rf_rd <= w_sel_rd;
          rf_wd <= w_sel_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. A behavioural model predicts the
// registered write-port outputs for every clock edge and pushes them to a
// scoreboard queue; scenario tasks pop and compare after each edge. Builds
// with or without WB_STARVE_GUARD_EN and adjusts expectations accordingly.

module tb_regfile_wb_arbiter;

  localparam int unsigned Limit = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [2:0]  rd;
    logic [15:0] wd;
    logic        rr_we;
    logic [15:0] rr_in;
  } out_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, a_ready, a_to_rr;
  logic [2:0]  a_rd;
  logic [15:0] a_data;
  logic        b_valid, b_ready, b_to_rr;
  logic [2:0]  b_rd;
  logic [15:0] b_data;
  logic        rf_we, rf_rr_we, b_starving;
  logic [2:0]  rf_rd;
  logic [15:0] rf_wd, rf_rr_in;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t sb_q[$];
  out_t m_out;
  int   m_cnt;

  regfile_wb_arbiter #(
    .STARVE_LIMIT(Limit),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_to_rr   (a_to_rr),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_to_rr   (b_to_rr),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .rf_rr_we  (rf_rr_we),
    .rf_rr_in  (rf_rr_in),
    .b_starving(b_starving)
  );

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    return {rf_we, rf_rd, rf_wd, rf_rr_we, rf_rr_in};
  endfunction

  function automatic logic m_force();
    return Guard && (m_cnt == int'(Limit));
  endfunction

  function automatic logic m_a_ready();
    return !(m_force() && b_valid);
  endfunction

  function automatic logic m_b_ready();
    return !a_valid || m_force();
  endfunction

  task automatic set_idle();
    a_valid = 1'b0; a_rd = 3'd0; a_data = 16'h0; a_to_rr = 1'b0;
    b_valid = 1'b0; b_rd = 3'd0; b_data = 16'h0; b_to_rr = 1'b0;
  endtask

  task automatic model_reset();
    m_out = '0;
    m_cnt = 0;
    sb_q.delete();
  endtask

  // Predicts the effect of the coming edge, queues it, then advances past it.
  task automatic tick(output logic gb);
    logic ga, sel_rr;
    logic [2:0] sel_rd;
    logic [15:0] sel_d;
    out_t nxt;
    ga = a_valid && m_a_ready();
    gb = b_valid && m_b_ready() && !ga;
    sel_rr = ga ? a_to_rr : b_to_rr;
    sel_rd = ga ? a_rd : b_rd;
    sel_d  = ga ? a_data : b_data;
    nxt = m_out;
    nxt.we = 1'b0;
    nxt.rr_we = 1'b0;
    if (ga || gb) begin
      if (sel_rr) begin
        nxt.rr_we = 1'b1; nxt.rr_in = sel_d;
      end else if (sel_rd != 3'd0) begin
        nxt.we = 1'b1; nxt.rd = sel_rd; nxt.wd = sel_d;
      end
    end
    if (Guard) begin
      if (b_valid && !m_b_ready()) m_cnt = (m_cnt == int'(Limit)) ? m_cnt : m_cnt + 1;
      else m_cnt = 0;
    end
    sb_q.push_back(nxt);
    m_out = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    #12;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (dut_out() !== out_t'(0)) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", dut_out(), out_t'(0));
    end
    n_checks++;
    if ({a_ready, b_ready, b_starving} !== 3'b110) begin
      n_fail++; $display("FAIL reset_ready: got %b want 110", {a_ready, b_ready, b_starving});
    end
  endtask

  task automatic test_gpr_write();
    out_t e;
    logic gb;
    set_idle();
    a_valid = 1'b1; a_rd = 3'd3; a_data = 16'h1234;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL gpr_a_ready: got %b want 1", a_ready);
    end
    tick(gb);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_out() !== e || e.we !== 1'b1) begin
      n_fail++; $display("FAIL gpr_write: got %h want %h", dut_out(), e);
    end
    set_idle();
    tick(gb);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_out() !== e) begin
      n_fail++; $display("FAIL gpr_pulse_end: got %h want %h", dut_out(), e);
    end
  endtask

  task automatic test_rr_write();
    out_t e;
    logic gb;
    set_idle();
    b_valid = 1'b1; b_to_rr = 1'b1; b_rd = 3'd2; b_data = 16'hBEEF;
    #1;
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fail++; $display("FAIL rr_b_ready: got %b want 1", b_ready);
    end
    tick(gb);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_out() !== e || rf_rr_in !== 16'hBEEF || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL rr_write: got %h want %h", dut_out(), e);
    end
    set_idle();
    tick(gb);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_out() !== e) begin
      n_fail++; $display("FAIL rr_pulse_end: got %h want %h", dut_out(), e);
    end
  endtask

  // Sustained A stream with B pending: B gets exactly the 5th slot when the
  // guard is built in, and none otherwise.
  task automatic test_back_to_back();
    out_t e;
    logic gb;
    int   b_slot;
    set_idle();
    b_valid = 1'b1; b_rd = 3'd5; b_data = 16'hB0B0;
    b_slot = -1;
    for (int i = 0; i < 10; i++) begin
      a_valid = 1'b1; a_rd = 3'(1 + (i % 7)); a_data = 16'(16'hA000 + i);
      #1;
      n_checks++;
      if ({a_ready, b_ready, b_starving} !== {m_a_ready(), m_b_ready(), m_force()}) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", i, {a_ready, b_ready, b_starving},
                 {m_a_ready(), m_b_ready(), m_force()});
      end
      tick(gb);
      if (gb && b_slot < 0) b_slot = i;
      e = sb_q.pop_front();
      n_checks++;
      if (dut_out() !== e) begin
        n_fail++; $display("FAIL b2b_out[%0d]: got %h want %h", i, dut_out(), e);
      end
      if (gb) b_valid = 1'b0;
    end
    n_checks++;
    if (b_slot !== (Guard ? int'(Limit) : -1)) begin
      n_fail++; $display("FAIL b2b_slot: got %0d want %0d", b_slot, Guard ? int'(Limit) : -1);
    end
    set_idle();
    tick(gb);
    void'(sb_q.pop_front());
  endtask

  task automatic test_rd_zero();
    out_t e;
    logic gb;
    set_idle();
    a_valid = 1'b1; a_rd = 3'd0; a_data = 16'hFFFF;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd0_a_ready: got %b want 1", a_ready);
    end
    tick(gb);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_out() !== e || rf_we !== 1'b0) begin
      n_fail++; $display("FAIL rd0_dropped: got %h want %h", dut_out(), e);
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    out_t e;
    logic gb;
    int   b_slot;
    set_idle();
    b_valid = 1'b1; b_rd = 3'd6; b_data = 16'h5A5A;
    #1;
    tick(gb);
    e = sb_q.pop_front();
    n_checks++;
    if (dut_out() !== e || rf_we !== 1'b1) begin
      n_fail++; $display("FAIL mid_b_write: got %h want %h", dut_out(), e);
    end
    // Build up some starvation count before the reset pulse.
    a_valid = 1'b1; a_rd = 3'd1; a_data = 16'h1111; b_data = 16'h6666;
    for (int i = 0; i < 2; i++) begin
      tick(gb);
      void'(sb_q.pop_front());
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_out() !== out_t'(0)) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h want %h", dut_out(), out_t'(0));
    end
    n_checks++;
    if ({a_ready, b_ready, b_starving} !== 3'b100) begin
      n_fail++; $display("FAIL mid_reset_ready: got %b want 100", {a_ready, b_ready, b_starving});
    end
    #3;
    reset_n = 1'b1;
    b_slot = -1;
    for (int i = 0; i < 7; i++) begin
      #1;
      tick(gb);
      if (gb && b_slot < 0) b_slot = i;
      e = sb_q.pop_front();
      n_checks++;
      if (dut_out() !== e) begin
        n_fail++; $display("FAIL mid_after_out[%0d]: got %h want %h", i, dut_out(), e);
      end
      if (gb) b_valid = 1'b0;
    end
    n_checks++;
    if (b_slot !== (Guard ? int'(Limit) : -1)) begin
      n_fail++; $display("FAIL mid_cnt_cleared: got %0d want %0d", b_slot, Guard ? int'(Limit) : -1);
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    reset_n = 1'b1;
    model_reset();
    test_reset();
    test_gpr_write();
    test_rr_write();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single GPR write port and single RR write port between two writeback sources.
  - Source A: the main ALU/load pipeline writeback stage.
  - Source B: the multi-cycle unit (mul/div), which returns results asynchronously to the pipeline.
- Uses fixed priority to A plus a starvation guard that eventually forces a B grant.
- Registers the winning write and drives clk-synchronous write controls straight into the register file.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles B may be refused before a B grant is forced (1..15).
- CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- a_valid  input  1  source A has a write pending.
- a_ready  output  1  source A write accepted this cycle when high with a_valid.
- a_rd  input  3  destination GPR index for A.
- a_data  input  16  write data for A.
- a_to_rr  input  1  A write targets RR instead of a GPR.
- b_valid  input  1  source B has a write pending.
- b_ready  output  1  source B write accepted this cycle when high with b_valid.
- b_rd  input  3  destination GPR index for B.
- b_data  input  16  write data for B.
- b_to_rr  input  1  B write targets RR instead of a GPR.
- rf_we  output  1  GPR write enable to the register file.
- rf_rd  output  3  GPR write index.
- rf_wd  output  16  GPR write data.
- rf_rr_we  output  1  RR write enable.
- rf_rr_in  output  16  RR write data.
- b_starving  output  1  force_b currently active (debug/perf).

Behaviour:
- Reset (reset_n low, async):
  - rf_we, rf_rr_we = 0; rf_rd = 0; rf_wd = 0; rf_rr_in = 0.
  - Starvation counter = 0; b_starving = 0.
  - A write pending in the output register is discarded.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - Sources hold valid, rd, data and to_rr stable until accepted; valid must not depend on ready.
- force_b = (starve_cnt == STARVE_LIMIT).
- Ready equations, combinational:
  - a_ready = !(force_b && b_valid).
  - b_ready = !a_valid || force_b.
  - At most one transfer per cycle.
- Grant:
  - grant_a = a_valid && a_ready.
  - grant_b = b_valid && b_ready && !grant_a.
- Output stage, registered, latency 1 cycle from the accepting edge; outputs are pulses, one cycle per transfer:
  - Granted write with to_rr = 0 and rd != 0: rf_we = 1, rf_rd = rd, rf_wd = data.
  - Granted write with to_rr = 1: rf_rr_we = 1, rf_rr_in = data; rf_we = 0.
  - Granted GPR write with rd = 0: accepted (ready honoured), but rf_we stays 0 (write dropped).
  - No grant: rf_we = 0, rf_rr_we = 0. rf_rd, rf_wd and rf_rr_in hold their last values.
- Starvation counter:
  - b_valid && !b_ready: increment, saturate at STARVE_LIMIT.
  - B transfer, or b_valid low: clear to 0.
  - b_starving = force_b, combinational from the counter.
- Simultaneous requests:
  - Normally A wins.
  - When force_b is set and b_valid is high, B wins and A sees a_ready = 0 for that cycle; the pipeline stalls A one cycle.
- Back-to-back:
  - A sustained A stream gives B exactly one slot every STARVE_LIMIT+1 cycles.
- Reset mid-operation:
  - Both readies evaluate from reset state (counter 0), so A is accepted if valid.
  - No partial write reaches the register file.

Optional Feature:
- Macro WB_STARVE_GUARD_EN.
  - Defined: starvation counter, force_b and b_starving behave as above.
  - Undefined: strict A priority. force_b is constant 0, the counter is not instantiated, and b_starving is tied 0. B can wait indefinitely under a sustained A stream.

Test Plan:
- Reset, then idle -> all rf_* outputs 0; a_ready = 1; b_ready = 1; b_starving = 0.
- a_valid, a_rd = 3, a_data = 16'h1234, 1 cycle -> next cycle rf_we = 1, rf_rd = 3, rf_wd = 16'h1234; following cycle rf_we = 0.
- b_valid, b_to_rr = 1, b_data = 16'hBEEF, A idle -> next cycle rf_rr_we = 1, rf_rr_in = 16'hBEEF, rf_we = 0.
- a_valid held high for 10 cycles and b_valid high, with guard enabled and STARVE_LIMIT = 4 -> b_ready low for 4 cycles; 5th cycle has b_starving = 1, a_ready = 0 and the B write lands next cycle; then A resumes. With guard disabled, B is never accepted during the 10 cycles.
- a_valid, a_rd = 0, a_data = 16'hFFFF -> a_ready = 1; rf_we stays 0 the next cycle.
- B accepted edge followed by reset_n pulsed low asynchronously before the next edge -> rf_we and rf_rr_we drop immediately and the counter clears to 0; no write is seen after reset release.
